// File: rtl/batch_output_arbiter.sv
// Batch-granular round-robin merge of per-instance conflict-detection streams
// into one AXI-Stream, with a single registered output stage.

module batch_output_arbiter_lane (
  input  logic granted,
  input  logic out_free,
  input  logic tvalid,
  output logic tready,
  output logic accept
);
  assign tready = granted & out_free;
  assign accept = tvalid & tready;
endmodule

module batch_output_arbiter #(
  parameter int NUM_INSTANCES    = 4,
  parameter int MAX_DEPENDENCIES = 256,
  parameter int MAX_GRANT_BEATS  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_INSTANCES-1:0]                  s_tvalid,
  output logic [NUM_INSTANCES-1:0]                  s_tready,
  input  logic [NUM_INSTANCES-1:0]                  s_tlast,
  input  logic [NUM_INSTANCES*64-1:0]               s_owner_programID,
  input  logic [NUM_INSTANCES*MAX_DEPENDENCIES-1:0] s_read_dependencies,
  input  logic [NUM_INSTANCES*MAX_DEPENDENCIES-1:0] s_write_dependencies,
  output logic                                      m_tvalid,
  input  logic                                      m_tready,
  output logic                                      m_tlast,
  output logic [$clog2(NUM_INSTANCES)-1:0]          m_tid,
  output logic [63:0]                               m_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]               m_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]               m_write_dependencies,
  output logic [31:0]                               grant_count,
  output logic [31:0]                               forced_release_count,
  output logic                                      busy
);
  localparam int IW = $clog2(NUM_INSTANCES);
  localparam int BW = (MAX_GRANT_BEATS > 1) ? $clog2(MAX_GRANT_BEATS) : 1;
  localparam int D  = MAX_DEPENDENCIES;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                   state;
  logic [IW-1:0]            grant, last_grant, nxt_grant;
  logic [BW-1:0]            beat_cnt;
  logic                     nxt_found, out_free, accept;
  logic [NUM_INSTANCES-1:0] lane_sel, lane_acc;

  assign out_free = !m_tvalid || m_tready;
  assign accept   = |lane_acc;
  assign busy     = (state == GRANTED) || m_tvalid;

  for (genvar i = 0; i < NUM_INSTANCES; i++) begin : g_lane
    assign lane_sel[i] = (state == GRANTED) && (grant == IW'(i));
    batch_output_arbiter_lane u_lane (
      .granted (lane_sel[i]),
      .out_free(out_free),
      .tvalid  (s_tvalid[i]),
      .tready  (s_tready[i]),
      .accept  (lane_acc[i])
    );
  end

  // Scan descending so the entry closest to last_grant+1 is written last and wins.
  always_comb begin
    logic [IW:0] idx;
    nxt_found = 1'b0;
    nxt_grant = '0;
    idx       = '0;
    for (int k = NUM_INSTANCES; k >= 1; k--) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_INSTANCES)) idx = idx - (IW+1)'(NUM_INSTANCES);
      if (s_tvalid[idx[IW-1:0]]) begin
        nxt_found = 1'b1;
        nxt_grant = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      grant                <= '0;
      last_grant           <= IW'(NUM_INSTANCES-1);
      beat_cnt             <= '0;
      m_tvalid             <= 1'b0;
      m_tlast              <= 1'b0;
      m_tid                <= '0;
      m_owner_programID    <= '0;
      m_read_dependencies  <= '0;
      m_write_dependencies <= '0;
      grant_count          <= '0;
      forced_release_count <= '0;
    end else begin
      if (accept) begin
        m_tvalid             <= 1'b1;
        m_tlast              <= s_tlast[grant];
        m_tid                <= grant;
        m_owner_programID    <= s_owner_programID[int'(grant)*64 +: 64];
        m_read_dependencies  <= s_read_dependencies[int'(grant)*D +: D];
        m_write_dependencies <= s_write_dependencies[int'(grant)*D +: D];
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (nxt_found) begin
            grant       <= nxt_grant;
            state       <= GRANTED;
            grant_count <= grant_count + 32'd1;
            beat_cnt    <= '0;
          end
        end
        GRANTED: begin
          // tlast takes priority, so a tlast on the cap beat is not a forced release
          if (accept) begin
            if (s_tlast[grant]) begin
              state      <= IDLE;
              last_grant <= grant;
            end else if (beat_cnt == BW'(MAX_GRANT_BEATS-1)) begin
              state                <= IDLE;
              last_grant           <= grant;
              forced_release_count <= forced_release_count + 32'd1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_batch_output_arbiter.sv
// Directed + randomized bench for batch_output_arbiter against a queue-level
// model of batch round-robin with a beat cap.

module tb_batch_output_arbiter;
  localparam int N  = 4;
  localparam int D  = 256;
  localparam int MG = 8;
  localparam int IW = $clog2(N);

  logic                  clk, rst_n;
  logic [N-1:0]          s_tvalid, s_tready, s_tlast;
  logic [N*64-1:0]       s_owner_programID;
  logic [N*D-1:0]        s_read_dependencies, s_write_dependencies;
  logic                  m_tvalid, m_tready, m_tlast;
  logic [IW-1:0]         m_tid;
  logic [63:0]           m_owner_programID;
  logic [D-1:0]          m_read_dependencies, m_write_dependencies;
  logic [31:0]           grant_count, forced_release_count;
  logic                  busy;

  batch_output_arbiter #(.NUM_INSTANCES(N), .MAX_DEPENDENCIES(D), .MAX_GRANT_BEATS(MG)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_owner_programID(s_owner_programID),
    .s_read_dependencies(s_read_dependencies),
    .s_write_dependencies(s_write_dependencies),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_owner_programID(m_owner_programID),
    .m_read_dependencies(m_read_dependencies),
    .m_write_dependencies(m_write_dependencies),
    .grant_count(grant_count), .forced_release_count(forced_release_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  pid;
    logic [D-1:0] rd;
    logic [D-1:0] wr;
    logic         last;
  } beat_t;

  typedef struct {
    beat_t b;
    int    tid;
    bit    eog;
  } exp_t;

  beat_t q [N][$];
  exp_t  expq[$];
  int    model_last = N-1;
  int    exp_grants, exp_forced;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] rnd_vec();
    logic [D-1:0] v;
    for (int i = 0; i < D; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  task automatic add_batch(input int inst, input int len, input bit tail_last);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.pid  = {$urandom, $urandom};
      b.rd   = rnd_vec();
      b.wr   = rnd_vec();
      b.last = tail_last && (j == len-1);
      q[inst].push_back(b);
    end
  endtask

  // Whole-transfer model: round-robin over non-empty sources, each grant drains
  // up to the end of its batch or MG beats, whichever comes first.
  function automatic void build_expected();
    beat_t c [N][$];
    exp_t  e;
    int    g, n;
    bit    done;
    for (int i = 0; i < N; i++) c[i] = q[i];
    expq.delete();
    exp_grants = 0;
    exp_forced = 0;
    forever begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && c[(model_last + k) % N].size() > 0) g = (model_last + k) % N;
      if (g < 0) break;
      exp_grants++;
      n = 0;
      done = 0;
      while (!done) begin
        e.b = c[g].pop_front();
        n++;
        done = e.b.last || (n == MG);
        if (!e.b.last && n == MG) exp_forced++;
        e.tid = g;
        e.eog = done;
        expq.push_back(e);
      end
      model_last = g;
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = q[i][0].last;
        s_owner_programID[i*64 +: 64]  = q[i][0].pid;
        s_read_dependencies[i*D +: D]  = q[i][0].rd;
        s_write_dependencies[i*D +: D] = q[i][0].wr;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  function automatic logic pick_ready(input int rmode, input int cyc, input int stall_at);
    if (rmode == 1) return (($urandom % 10) < 7);
    if (rmode == 2) return !(cyc >= stall_at && cyc < stall_at + 5);
    return 1'b1;
  endfunction

  // rmode 0: ready always high (cycle gaps checked); 1: random ready; 2: 5-cycle stall at stall_at
  task automatic run(input string tag, input int rmode, input int stall_at, input int exp_first);
    logic [31:0]   g0, f0;
    logic [N-1:0]  fire_in;
    logic [63:0]   ppid;
    logic [D-1:0]  prd, pwr;
    logic [IW-1:0] ptid;
    logic          plast, pv, pr;
    exp_t          e;
    int            cyc, first, nbeat, prev_cyc;
    bit            prev_eog;
    g0 = grant_count;
    f0 = forced_release_count;
    build_expected();
    drive();
    m_tready = pick_ready(rmode, 0, stall_at);
    #1;
    cyc = 0; first = -1; nbeat = 0; prev_cyc = 0; prev_eog = 0; pv = 0; pr = 0;
    ppid = '0; prd = '0; pwr = '0; ptid = '0; plast = 0;
    while ((expq.size() > 0 || m_tvalid) && cyc < 3000) begin
      if (pv && !pr) begin
        chk({tag, "_hold_vld"}, 256'(m_tvalid), 256'(1));
        chk({tag, "_hold_pid"}, 256'(m_owner_programID), 256'(ppid));
        chk({tag, "_hold_rd"},  256'(m_read_dependencies), 256'(prd));
        chk({tag, "_hold_tid"}, 256'({plast, m_tid}), 256'({m_tlast, ptid}));
      end
      if (m_tvalid && !m_tready) chk({tag, "_stall_rdy"}, 256'(s_tready), 256'(0));
      if (m_tvalid && first < 0) first = cyc;
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          chk({tag, "_extra_beat"}, 256'(1), 256'(0));
        end else begin
          e = expq.pop_front();
          chk({tag, "_tid"},  256'(m_tid), 256'(e.tid));
          chk({tag, "_pid"},  256'(m_owner_programID), 256'(e.b.pid));
          chk({tag, "_rd"},   256'(m_read_dependencies), 256'(e.b.rd));
          chk({tag, "_wr"},   256'(m_write_dependencies), 256'(e.b.wr));
          chk({tag, "_last"}, 256'(m_tlast), 256'(e.b.last));
          if (rmode == 0 && nbeat > 0)
            chk({tag, "_gap"}, 256'(cyc - prev_cyc), 256'(prev_eog ? 2 : 1));
          prev_cyc = cyc;
          prev_eog = e.eog;
          nbeat++;
        end
      end
      fire_in = s_tvalid & s_tready;
      pv = m_tvalid; pr = m_tready; ppid = m_owner_programID;
      prd = m_read_dependencies; pwr = m_write_dependencies; ptid = m_tid; plast = m_tlast;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire_in[i]) void'(q[i].pop_front());
      cyc++;
      drive();
      m_tready = pick_ready(rmode, cyc, stall_at);
      #1;
    end
    chk({tag, "_timeout"}, 256'(cyc < 3000), 256'(1));
    chk({tag, "_missing"}, 256'(expq.size()), 256'(0));
    chk({tag, "_grants"},  256'(grant_count - g0), 256'(32'(exp_grants)));
    chk({tag, "_forced"},  256'(forced_release_count - f0), 256'(32'(exp_forced)));
    chk({tag, "_idle_busy"}, 256'(busy), 256'(0));
    if (exp_first >= 0) chk({tag, "_first_lat"}, 256'(first), 256'(exp_first));
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    s_owner_programID = '0; s_read_dependencies = '0; s_write_dependencies = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_s_tready", 256'(s_tready), 256'(0));
    chk("rst_grants",   256'(grant_count), 256'(0));
    chk("rst_forced",   256'(forced_release_count), 256'(0));
    chk("rst_busy",     256'(busy), 256'(0));
    chk("rst_out",      256'({m_tlast, m_tid, m_owner_programID}), 256'(0));
    rst_n = 1'b1;
    #1;

    add_batch(0, 3, 1);
    run("single", 0, 0, 2);
    chk("single_grant_abs", 256'(grant_count), 256'(1));

    for (int i = 0; i < N; i++) begin
      add_batch(i, 2, 1);
      add_batch(i, 2, 1);
    end
    run("rr2beat", 0, 0, -1);

    add_batch(2, 20, 1);
    add_batch(3, 2, 1);
    run("cap", 0, 0, -1);

    add_batch(1, 6, 1);
    run("stall", 2, 4, 2);

    add_batch(0, MG, 1);
    add_batch(3, MG + 1, 1);
    run("tlast_at_cap", 0, 0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) add_batch(i, $urandom_range(1, 12), 1);
      end
      run("rand", 1, 0, -1);
    end

    for (int i = 0; i < N; i++) add_batch(i, 3, 1);
    drive();
    m_tready = 1'b0;
    waited = 0;
    while (!m_tvalid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("rst_mid_reach", 256'(m_tvalid), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld",    256'(m_tvalid), 256'(0));
    chk("rst_mid_cnt",    256'({grant_count, forced_release_count}), 256'(0));
    chk("rst_mid_busy",   256'(busy), 256'(0));
    chk("rst_mid_tready", 256'(s_tready), 256'(0));
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    model_last = N-1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) add_batch(i, 1, 1);
    run("post_rst", 0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
